// File: rtl/logic_unit_pipe.sv
// Purpose : bitwise logic unit (NAND/AND/OR/NOR/XOR/XNOR/NOT A/PASS A) with zero/all-ones flags.
// Latency : 1 cycle from accepting edge to y/out_valid when the output register is free or draining.
// Backpr. : one-entry skid buffer; in_ready is registered (~skid_full), no out_ready->in_ready path.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid/in_ready        - upstream handshake for a, b, op
//   a, b [WIDTH-1:0], op[2:0]- operands and operation select
//   out_valid/out_ready      - downstream handshake for y, zero, ones
//   y [WIDTH-1:0]            - registered result
//   zero, ones               - y == 0 / y == all ones, registered alongside y
module logic_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones
);

    typedef enum logic [2:0] {
        OP_NAND = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_NOR  = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_PASA = 3'b111
    } op_e;

    // Result word carried through both storage slots.
    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             zero;
        logic             ones;
    } res_t;

    res_t out_q,       out_d;
    res_t skid_q,      skid_d;
    logic out_valid_q, out_valid_d;
    logic skid_full_q, skid_full_d;

    res_t res;
    logic acc;
    logic drn;

    // Combinational operation on the incoming operands.
    always_comb begin
        res.y = '0;
        unique case (op_e'(op))
            OP_NAND: res.y = ~(a & b);
            OP_AND:  res.y = a & b;
            OP_OR:   res.y = a | b;
            OP_NOR:  res.y = ~(a | b);
            OP_XOR:  res.y = a ^ b;
            OP_XNOR: res.y = ~(a ^ b);
            OP_NOTA: res.y = ~a;
            OP_PASA: res.y = a;
            default: res.y = '0;
        endcase
        res.zero = (res.y == '0);
        res.ones = (res.y == '1);
    end

    assign acc = in_valid & ~skid_full_q;
    assign drn = out_valid_q & out_ready;

    // Occupancy: EMPTY (!out_valid), HOLD (out_valid, !skid_full), FULL (both).
    always_comb begin
        out_d       = out_q;
        skid_d      = skid_q;
        out_valid_d = out_valid_q;
        skid_full_d = skid_full_q;

        if (!out_valid_q) begin
            if (acc) begin
                out_d       = res;
                out_valid_d = 1'b1;
            end
        end else if (!skid_full_q) begin
            if (acc && drn) begin
                out_d = res;
            end else if (acc) begin
                // Output is stalled: park the new result in the skid entry.
                skid_d      = res;
                skid_full_d = 1'b1;
            end else if (drn) begin
                // y keeps its last value; only the valid bit drops.
                out_valid_d = 1'b0;
            end
        end else begin
            // FULL: in_ready is low, so only a drain can move anything.
            if (drn) begin
                out_d       = skid_q;
                skid_full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
        end
    end

    assign in_ready  = ~skid_full_q;
    assign out_valid = out_valid_q;
    assign y         = out_q.y;
    assign zero      = out_q.zero;
    assign ones      = out_q.ones;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Purpose : directed self-checking bench for logic_unit_pipe (WIDTH=8 and WIDTH=1 instances).
// Latency : inputs driven 1 time unit after each rising edge, outputs checked at the same point.
// Backpr. : exercises skid fill, stall, drain, bubbles and reset while full.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, y;
    logic [2:0] op;
    logic       zero, ones;

    logic       in_valid1, in_ready1, out_valid1, out_ready1;
    logic [0:0] a1, b1, y1;
    logic [2:0] op1;
    logic       zero1, ones1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_y [8];

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .ones(ones)
    );

    logic_unit_pipe #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .op(op1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .y(y1), .zero(zero1), .ones(ones1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_y = '{8'hFC, 8'h03, 8'h3F, 8'hC0, 8'h3C, 8'hC3, 8'hF0, 8'h0F};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; op1 = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_y",         y,         0);
        check("rst_zero",      zero,      0);
        check("rst_ones",      ones,      0);
        check("rst_in_ready",  in_ready,  1);

        // All eight ops back to back, full throughput.
        out_ready = 1'b1; in_valid = 1'b1; a = 8'h0F; b = 8'h33;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            tick();
            check($sformatf("op%0d_y", i), y, exp_y[i]);
            check($sformatf("op%0d_vld", i), out_valid, 1);
        end
        in_valid = 1'b0;
        tick();
        check("ops_drained", out_valid, 0);

        // Flags.
        in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 3'b001;
        tick();
        check("and_ff_y",    y,    8'hFF);
        check("and_ff_ones", ones, 1);
        check("and_ff_zero", zero, 0);
        op = 3'b000;
        tick();
        check("nand_ff_y",    y,    8'h00);
        check("nand_ff_zero", zero, 1);
        check("nand_ff_ones", ones, 0);
        in_valid = 1'b0;
        tick();

        // Backpressure through the skid entry.
        out_ready = 1'b0; in_valid = 1'b1; op = 3'b001; b = 8'hFF; a = 8'h01;
        check("bp_rdy0", in_ready, 1);
        tick();
        check("bp_y1", y, 8'h01);
        a = 8'h02;
        check("bp_rdy1", in_ready, 1);
        tick();
        check("bp_rdy_full", in_ready, 0);
        check("bp_y_held", y, 8'h01);
        a = 8'h04;
        tick();
        check("bp_rdy_still0", in_ready, 0);
        check("bp_y_still01",  y, 8'h01);
        check("bp_vld_held",   out_valid, 1);
        out_ready = 1'b1;
        tick();
        check("bp_y2",         y, 8'h02);
        check("bp_rdy_back",   in_ready, 1);
        tick();
        check("bp_y3",         y, 8'h04);
        in_valid = 1'b0;
        tick();
        check("bp_empty_vld",  out_valid, 0);
        check("bp_empty_y",    y, 8'h04);

        // Bubble.
        in_valid = 1'b1; a = 8'h55; op = 3'b111;
        tick();
        check("bub_vld1", out_valid, 1);
        check("bub_y1",   y, 8'h55);
        in_valid = 1'b0; a = 8'h99;
        tick();
        check("bub_vld0", out_valid, 0);
        check("bub_y_kept", y, 8'h55);
        in_valid = 1'b1; a = 8'hAA;
        tick();
        check("bub_vld2", out_valid, 1);
        check("bub_y2",   y, 8'hAA);
        in_valid = 1'b0;
        tick();

        // Reset while FULL; inputs during reset are ignored.
        out_ready = 1'b0; in_valid = 1'b1; op = 3'b111; a = 8'h11;
        tick();
        a = 8'h22;
        tick();
        check("rf_full", in_ready, 0);
        rst = 1'b1; a = 8'h33;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rf_vld",   out_valid, 0);
        check("rf_y",     y,         0);
        check("rf_zero",  zero,      0);
        check("rf_ones",  ones,      0);
        check("rf_rdy",   in_ready,  1);
        out_ready = 1'b1;
        tick();
        check("rf_no_skid1", out_valid, 0);
        tick();
        check("rf_no_skid2", out_valid, 0);

        // WIDTH=1 instance.
        in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b0; op1 = 3'b100;
        tick();
        check("w1_xor_y",    y1,    1);
        check("w1_xor_ones", ones1, 1);
        check("w1_xor_zero", zero1, 0);
        op1 = 3'b101;
        tick();
        check("w1_xnor_y",    y1,    0);
        check("w1_xnor_zero", zero1, 1);
        check("w1_xnor_ones", ones1, 0);
        in_valid1 = 1'b0;
        tick();
        check("w1_drained", out_valid1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the fixed 4-bit quad NAND gate block.
- Computes one of eight bitwise operations on two WIDTH-bit operands.
- Result is registered behind a valid/ready handshake, with a one-entry skid buffer for full throughput under backpressure.
- Sits between the CPU operand buses and the ALU result mux; supplies zero/all-ones flags to the flags register.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 1).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream presents a, b, op this cycle
- in_ready  output  1  block can accept; transfer when in_valid & in_ready
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  operation select, sampled with a/b on transfer
- out_valid  output  1  y/zero/ones hold a valid result
- out_ready  input  1  downstream consumes; transfer when out_valid & out_ready
- y  output  WIDTH  registered result
- zero  output  1  y == 0, registered with y
- ones  output  1  y == all ones, registered with y

Behaviour:
- Op encoding:
  - 000 NAND (~(a&b))
  - 001 AND
  - 010 OR
  - 011 NOR
  - 100 XOR
  - 101 XNOR
  - 110 NOT A (b ignored)
  - 111 PASS A (b ignored)
- All ops are bitwise and width-exact; no carries, no sign handling.
- Storage: output register (OUT: y, zero, ones, out_valid) plus one skid entry (SKID: data, flags, skid_full).
- States by occupancy:
  - EMPTY: out_valid=0, skid_full=0
  - HOLD: out_valid=1, skid_full=0
  - FULL: out_valid=1, skid_full=1
- in_ready = ~skid_full. It is a register output; no combinational path from out_ready to in_ready.
- Latency: accepted input appears on y/out_valid exactly 1 cycle after the accepting edge, when OUT is empty or being drained that cycle.
- Per-edge rules (acc = in_valid & in_ready, drn = out_valid & out_ready):
  - EMPTY, acc: OUT <= result; go to HOLD.
  - HOLD, acc & drn: OUT <= result; stay in HOLD.
  - HOLD, acc & ~drn: SKID <= result; go to FULL.
  - HOLD, ~acc & drn: go to EMPTY (out_valid=0; y keeps last value).
  - FULL, drn: OUT <= SKID; go to HOLD; in_ready returns to 1 the next cycle.
  - FULL, ~drn: hold everything.
  - Any state, no acc and no drn: hold.
- Order preserved; no result is dropped or duplicated.
- y, zero and ones are stable while out_valid=1 and out_ready=0.
- Sustained throughput is 1 result/cycle with out_ready=1.
- Reset (any cycle, including mid-transfer or FULL):
  - y=0, zero=0, ones=0, out_valid=0, skid_full=0, skid data=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Inputs are ignored while rst=1.
- Flags: zero and ones are meaningful only when out_valid=1.
- WIDTH=1: zero and ones are complementary whenever out_valid=1.

Test Plan:
- WIDTH=8, out_ready=1, a=0x0F, b=0x33, op stepped 0..7 on consecutive cycles -> y one cycle later = FC, 03, 3F, C0, 3C, C3, F0, 0F; out_valid held high throughout.
- Flags: a=0xFF, b=0xFF, op=001 -> y=FF, ones=1, zero=0. Then op=000 -> y=00, zero=1, ones=0.
- Backpressure: out_ready=0, offer three AND ops (a=01,02,04; b=FF) on consecutive cycles -> y=01 held, second result skidded, in_ready=0 from the third cycle, third input not accepted. Raise out_ready -> y sequence 01, 02, 04, with third accepted once in_ready=1.
- Bubble: in_valid toggled 1,0,1 with out_ready=1 -> out_valid pattern 1,0,1 delayed one cycle; y unchanged during the bubble.
- Reset in FULL: assert rst for one cycle -> next cycle out_valid=0, y=00, zero=0, ones=0, in_ready=1. The skidded result never appears.
- WIDTH=1 instance: a=1, b=0, op=100 -> y=1, ones=1, zero=0.
